countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 28 ++
 rtl/countdown_timer_if.sv | 25 ++
 rtl/countdown_timer_key_edge.sv | 31 +++
 rtl/led7_decoder.sv | 23 ++
 rtl/countdown_timer.sv | 133 +++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, field limits
// and default timing constants.
package countdown_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam logic [5:0] FIELD_MAX         = 6'd59;
    localparam int         DEFAULT_CLK_DIV   = 50000000;
    localparam int         DEFAULT_ALARM_LEN = 10;

    // Step a minutes/seconds field by one, wrapping inside 0..FIELD_MAX.
    function automatic logic [5:0] field_step(input logic [5:0] f, input logic up);
        logic [5:0] r;
        if (up) begin
            r = (f >= FIELD_MAX) ? 6'd0 : f + 6'd1;
        end else begin
            r = (f == 6'd0) ? FIELD_MAX : f - 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Operator-facing signal bundle of the countdown timer: keys and mode levels
// in, 7-segment digits and status flags out.
interface countdown_timer_if;
    logic       key1;
    logic       key2;
    logic       key_start;
    logic       mode;
    logic       select;
    logic [6:0] M1;
    logic [6:0] M2;
    logic [6:0] S1;
    logic [6:0] S2;
    logic       running;
    logic       alarm;

    modport master (
        output key1, key2, key_start, mode, select,
        input  M1, M2, S1, S2, running, alarm
    );

    modport slave (
        input  key1, key2, key_start, mode, select,
        output M1, M2, S1, S2, running, alarm
    );
endinterface

// File: rtl/countdown_timer_key_edge.sv
// Two-flop synchronizer for an active-low key plus a one-cycle press pulse
// on each registered 1->0 transition.
module key_edge (
    input  logic clk_50,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    logic       sync1_r;
    logic       sync2_r;
    logic       prev_r;
    logic [2:0] fill_r;

    // Synchronize the key; fill_r marks when prev_r holds a real post-reset sample.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            fill_r  <= 3'b000;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            fill_r  <= {fill_r[1:0], 1'b1};
        end
    end

    // A key held low through reset release never looks like a fresh edge.
    assign press = fill_r[2] & prev_r & ~sync2_r;
endmodule

// File: rtl/led7_decoder.sv
// BCD digit to 7-segment pattern, active-high segments ordered {g,f,e,d,c,b,a}.
module led7_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // Segment lookup; non-decimal codes blank the display.
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with set/run/pause modes, 1 s prescaler and a
// timed alarm, shown on four 7-segment digits.
import countdown_timer_pkg::*;

module countdown_timer #(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int ALARM_LEN = DEFAULT_ALARM_LEN
) (
    input  logic              clk_50,
    input  logic              rst,
    countdown_timer_if.slave  bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_LEN - 1);

    state_t         state_r;
    logic [5:0]     min_r;
    logic [5:0]     sec_r;
    logic [PW-1:0]  presc_r;
    logic [AW-1:0]  alarm_cnt_r;
    logic           running_r;
    logic           alarm_r;

    logic k1_press_s, k2_press_s, ks_press_s;
    logic inc_s, dec_s, any_press_s, tick_s, nonzero_s, last_s;
    logic [6:0] m1_seg_s, m2_seg_s, s1_seg_s, s2_seg_s;

    key_edge u_key1 (.clk_50(clk_50), .rst(rst), .key_n(bus.key1),      .press(k1_press_s));
    key_edge u_key2 (.clk_50(clk_50), .rst(rst), .key_n(bus.key2),      .press(k2_press_s));
    key_edge u_keys (.clk_50(clk_50), .rst(rst), .key_n(bus.key_start), .press(ks_press_s));

    assign inc_s       = k1_press_s & ~k2_press_s;
    assign dec_s       = k2_press_s & ~k1_press_s;
    assign any_press_s = k1_press_s | k2_press_s | ks_press_s;
    assign tick_s      = (presc_r == PRESC_LAST);
    assign nonzero_s   = (min_r != 6'd0) || (sec_r != 6'd0);
    assign last_s      = (min_r == 6'd0) && (sec_r == 6'd1);

    // Timer FSM: state, value, prescaler, alarm length and status flags.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            min_r       <= 6'd0;
            sec_r       <= 6'd0;
            presc_r     <= '0;
            alarm_cnt_r <= '0;
            running_r   <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_PAUSE: begin
                    if (bus.mode) begin
                        state_r <= ST_SET;
                    end else if (ks_press_s && nonzero_s) begin
                        state_r   <= ST_RUN;
                        presc_r   <= '0;
                        running_r <= 1'b1;
                    end
                end
                ST_SET: begin
                    if (inc_s || dec_s) begin
                        if (bus.select) begin
                            min_r <= field_step(min_r, inc_s);
                        end else begin
                            sec_r <= field_step(sec_r, inc_s);
                        end
                    end
                    if (!bus.mode) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (ks_press_s) begin
                        state_r   <= ST_PAUSE;
                        running_r <= 1'b0;
                    end else begin
                        presc_r <= tick_s ? '0 : presc_r + PW'(1);
                        if (tick_s) begin
                            if (sec_r == 6'd0) begin
                                sec_r <= FIELD_MAX;
                                min_r <= min_r - 6'd1;
                            end else begin
                                sec_r <= sec_r - 6'd1;
                            end
                            // The tick that reaches 00:00 raises the alarm on the same edge.
                            if (last_s) begin
                                state_r     <= ST_ALARM;
                                running_r   <= 1'b0;
                                alarm_r     <= 1'b1;
                                alarm_cnt_r <= '0;
                            end
                        end
                    end
                end
                ST_ALARM: begin
                    if (any_press_s) begin
                        state_r <= ST_IDLE;
                        alarm_r <= 1'b0;
                    end else begin
                        presc_r <= tick_s ? '0 : presc_r + PW'(1);
                        if (tick_s) begin
                            if (alarm_cnt_r == ALARM_LAST) begin
                                state_r <= ST_IDLE;
                                alarm_r <= 1'b0;
                            end else begin
                                alarm_cnt_r <= alarm_cnt_r + AW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    alarm_r   <= 1'b0;
                end
            endcase
        end
    end

    led7_decoder u_m1 (.digit(4'(min_r / 6'd10)), .seg(m1_seg_s));
    led7_decoder u_m2 (.digit(4'(min_r % 6'd10)), .seg(m2_seg_s));
    led7_decoder u_s1 (.digit(4'(sec_r / 6'd10)), .seg(s1_seg_s));
    led7_decoder u_s2 (.digit(4'(sec_r % 6'd10)), .seg(s2_seg_s));

    assign bus.M1      = m1_seg_s;
    assign bus.M2      = m2_seg_s;
    assign bus.S1      = s1_seg_s;
    assign bus.S2      = s2_seg_s;
    assign bus.running = running_r;
    assign bus.alarm   = alarm_r;
endmodule
